gpi_debouncer: RTL and testbench

//  Input conditioner for the 4 front-panel push-buttons (gpi) ahead of the CPU core in soc.
//  Per channel: 2-FF synchroniser, debounce counter, stable level, one-cycle press pulse
//  and a sticky pending flag. Pending flags are cleared by a per-channel ack from the core.

---
 rtl/gpi_debouncer.sv | 84 ++++++++
 tb/tb_gpi_debouncer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpi_debouncer.sv
// rtl/gpi_debouncer.sv - front-panel button synchroniser, debouncer, press pulse and pending-event latch
// Each channel is filtered independently; evt_code reports the highest pending channel.
module gpi_debouncer #(
  parameter int CLK_PERIOD_ns    = 20,
  parameter int DEBOUNCE_TIME_ns = 0,
  parameter int WIDTH            = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] gpi,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] pending,
  input  logic [WIDTH-1:0] ack,
  output logic             evt_valid,
  output logic [2:0]       evt_code
);

  localparam int N  = DEBOUNCE_TIME_ns / CLK_PERIOD_ns;
  localparam int NM = (N < 1) ? 1 : N;
  localparam int CW = $clog2(NM) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NM - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] level_d;
  logic [WIDTH-1:0] rise;
  logic [CW-1:0]    cnt [WIDTH];

  assign rise = level & ~level_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= gpi;
      s2 <= s1;
    end
  end

  // Any cycle where s2 agrees with level restarts the stability count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (N == 0) begin
          level[i] <= s2[i];
        end else if (s2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          level[i] <= s2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // A fresh rise beats a simultaneous ack so no press is ever lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level_d <= '0;
      press   <= '0;
      pending <= '0;
    end else begin
      level_d <= level;
      press   <= rise;
      pending <= (pending & ~ack) | rise;
    end
  end

  always_comb begin
    evt_code = 3'd0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pending[i]) evt_code = 3'(i);
    end
    evt_valid = |pending;
  end

endmodule

// File: tb/tb_gpi_debouncer.sv
// tb/tb_gpi_debouncer.sv - self-checking bench for gpi_debouncer (N=0 and N=5 instances)
// Both instances share stimulus; a window-based reference model tracks expected outputs.
module tb_gpi_debouncer;

  localparam int W  = 4;
  localparam int NB = 5;

  logic         clk    = 1'b0;
  logic         resetn = 1'b1;
  logic [W-1:0] gpi    = '0;
  logic [W-1:0] ack    = '0;
  logic [W-1:0] a_level, a_press, a_pend;
  logic [W-1:0] b_level, b_press, b_pend;
  logic         a_ev, b_ev;
  logic [2:0]   a_code, b_code;
  int           errs   = 0;
  int           checks = 0;

  always #10 clk = ~clk;

  gpi_debouncer #(.CLK_PERIOD_ns(20), .DEBOUNCE_TIME_ns(0), .WIDTH(W)) dut_a (
    .clk(clk), .resetn(resetn), .gpi(gpi), .level(a_level), .press(a_press),
    .pending(a_pend), .ack(ack), .evt_valid(a_ev), .evt_code(a_code)
  );

  gpi_debouncer #(.CLK_PERIOD_ns(20), .DEBOUNCE_TIME_ns(100), .WIDTH(W)) dut_b (
    .clk(clk), .resetn(resetn), .gpi(gpi), .level(b_level), .press(b_press),
    .pending(b_pend), .ack(ack), .evt_valid(b_ev), .evt_code(b_code)
  );

  // Reference: level flips once the newest max(N,1) synchronised samples all disagree with it.
  logic [W-1:0]  m_s1, m_s2;
  logic [15:0]   m_hist [2][W];
  logic [W-1:0]  m_lvl [2];
  logic [W-1:0]  m_lvl_d [2];
  logic [W-1:0]  m_prs [2];
  logic [W-1:0]  m_pnd [2];

  function automatic logic all_differ(logic lvl, logic [15:0] h, int nm);
    for (int j = 0; j < nm; j++) if (h[j] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [2:0] top_idx(logic [W-1:0] p);
    for (int i = W - 1; i >= 0; i--) if (p[i]) return 3'(i);
    return 3'd0;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_s1 <= '0;
      m_s2 <= '0;
      for (int k = 0; k < 2; k++) begin
        m_lvl[k]   <= '0;
        m_lvl_d[k] <= '0;
        m_prs[k]   <= '0;
        m_pnd[k]   <= '0;
        for (int c = 0; c < W; c++) m_hist[k][c] <= '0;
      end
    end else begin
      m_s1 <= gpi;
      m_s2 <= m_s1;
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < W; c++) begin
          m_hist[k][c] <= {m_hist[k][c][14:0], m_s2[c]};
          if (all_differ(m_lvl[k][c], {m_hist[k][c][14:0], m_s2[c]}, (k == 0) ? 1 : NB))
            m_lvl[k][c] <= ~m_lvl[k][c];
        end
        m_lvl_d[k] <= m_lvl[k];
        m_prs[k]   <= m_lvl[k] & ~m_lvl_d[k];
        m_pnd[k]   <= (m_pnd[k] & ~ack) | (m_lvl[k] & ~m_lvl_d[k]);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    gpi = '0;
    ack = '0;
    repeat (14) tick();
    ack = '1;
    tick();
    ack = '0;
    tick();
  endtask

  task automatic test_reset();
    #5 resetn = 1'b0;
    gpi = '1;
    repeat (3) tick();
    checks++; if ({a_level, a_press, a_pend} !== '0) begin errs++; $display("FAIL reset_a_state got %h exp 0", {a_level, a_press, a_pend}); end
    checks++; if ({a_ev, a_code} !== 4'd0) begin errs++; $display("FAIL reset_a_evt got %h exp 0", {a_ev, a_code}); end
    checks++; if ({b_level, b_press, b_pend} !== '0) begin errs++; $display("FAIL reset_b_state got %h exp 0", {b_level, b_press, b_pend}); end
    checks++; if ({b_ev, b_code} !== 4'd0) begin errs++; $display("FAIL reset_b_evt got %h exp 0", {b_ev, b_code}); end
    gpi = '0;
    tick();
    resetn = 1'b1;
    repeat (3) tick();
    checks++; if ({a_level, a_pend, b_level, b_pend} !== '0) begin errs++; $display("FAIL reset_release got %h exp 0", {a_level, a_pend, b_level, b_pend}); end
  endtask

  task automatic test_n0();
    gpi = 4'b1000;
    for (int j = 1; j <= 6; j++) begin
      tick();
      checks++; if (a_level[3] !== (j >= 3)) begin errs++; $display("FAIL n0_level edge %0d got %b exp %b", j, a_level[3], j >= 3); end
      checks++; if (a_press !== ((j == 4) ? 4'b1000 : 4'b0000)) begin errs++; $display("FAIL n0_press edge %0d got %b", j, a_press); end
      checks++; if (a_pend[3] !== (j >= 4)) begin errs++; $display("FAIL n0_pending edge %0d got %b exp %b", j, a_pend[3], j >= 4); end
      checks++; if (a_code !== ((j >= 4) ? 3'd3 : 3'd0)) begin errs++; $display("FAIL n0_code edge %0d got %0d", j, a_code); end
    end
    settle();
  endtask

  task automatic test_glitch();
    for (int t = 0; t < 30; t++) begin
      gpi = {3'b000, (t < 14) && ((t % 5) != 4)};
      tick();
      checks++; if ({b_level[0], b_press[0], b_pend[0]} !== 3'b000) begin errs++; $display("FAIL glitch cycle %0d got %b exp 000", t, {b_level[0], b_press[0], b_pend[0]}); end
    end
    settle();
  endtask

  task automatic test_hold();
    gpi = 4'b0010;
    for (int j = 1; j <= 20; j++) begin
      tick();
      checks++; if (b_level[1] !== (j >= 7)) begin errs++; $display("FAIL hold_level edge %0d got %b exp %b", j, b_level[1], j >= 7); end
      checks++; if (b_press[1] !== (j == 8)) begin errs++; $display("FAIL hold_press edge %0d got %b exp %b", j, b_press[1], j == 8); end
      checks++; if (b_pend[1] !== (j >= 8)) begin errs++; $display("FAIL hold_pending edge %0d got %b exp %b", j, b_pend[1], j >= 8); end
    end
    gpi = 4'b0000;
    for (int j = 21; j <= 32; j++) begin
      tick();
      checks++; if (b_level[1] !== (j < 27)) begin errs++; $display("FAIL release_level edge %0d got %b exp %b", j, b_level[1], j < 27); end
      checks++; if (b_press !== 4'b0000) begin errs++; $display("FAIL release_press edge %0d got %b exp 0000", j, b_press); end
    end
    settle();
  endtask

  task automatic test_evt();
    gpi = 4'b0101;
    repeat (5) tick();
    checks++; if (a_pend !== 4'b0101) begin errs++; $display("FAIL evt_pending got %b exp 0101", a_pend); end
    checks++; if ({a_ev, a_code} !== {1'b1, 3'd2}) begin errs++; $display("FAIL evt_code2 got %b/%0d exp 1/2", a_ev, a_code); end
    ack = 4'b0100;
    tick();
    ack = 4'b0000;
    checks++; if (a_pend !== 4'b0001) begin errs++; $display("FAIL evt_ack2 got %b exp 0001", a_pend); end
    checks++; if ({a_ev, a_code} !== {1'b1, 3'd0}) begin errs++; $display("FAIL evt_code0 got %b/%0d exp 1/0", a_ev, a_code); end
    ack = 4'b1000;
    tick();
    ack = 4'b0000;
    checks++; if (a_pend !== 4'b0001) begin errs++; $display("FAIL evt_ack_clear_bit got %b exp 0001", a_pend); end
    ack = 4'b0001;
    gpi = 4'b0100;
    tick();
    ack = 4'b0000;
    checks++; if ({a_ev, a_pend} !== 5'b0) begin errs++; $display("FAIL evt_cleared got %b/%b exp 0/0000", a_ev, a_pend); end
    repeat (4) tick();
    gpi = 4'b0101;
    repeat (3) tick();
    ack = 4'b0001;
    tick();
    ack = 4'b0000;
    checks++; if (a_press !== 4'b0001) begin errs++; $display("FAIL evt_repress got %b exp 0001", a_press); end
    checks++; if (a_pend !== 4'b0001) begin errs++; $display("FAIL evt_set_beats_ack got %b exp 0001", a_pend); end
    ack = 4'b0001;
    tick();
    ack = 4'b0000;
    checks++; if (a_pend !== 4'b0000) begin errs++; $display("FAIL evt_ack0 got %b exp 0000", a_pend); end
    settle();
  endtask

  task automatic test_reset_mid();
    gpi = 4'b1000;
    repeat (5) tick();
    checks++; if ({a_level[3], a_pend[3], b_level[3]} !== 3'b110) begin errs++; $display("FAIL rmid_pre got %b exp 110", {a_level[3], a_pend[3], b_level[3]}); end
    #3 resetn = 1'b0;
    #1;
    checks++; if ({a_level, a_press, a_pend, a_ev, a_code} !== '0) begin errs++; $display("FAIL rmid_async_a got %h exp 0", {a_level, a_press, a_pend, a_ev, a_code}); end
    checks++; if ({b_level, b_press, b_pend, b_ev, b_code} !== '0) begin errs++; $display("FAIL rmid_async_b got %h exp 0", {b_level, b_press, b_pend, b_ev, b_code}); end
    @(posedge clk);
    @(posedge clk);
    tick();
    resetn = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      checks++; if (b_level[3] !== (j >= 7)) begin errs++; $display("FAIL rmid_level edge %0d got %b exp %b", j, b_level[3], j >= 7); end
      checks++; if (b_press[3] !== (j == 8)) begin errs++; $display("FAIL rmid_press edge %0d got %b exp %b", j, b_press[3], j == 8); end
      checks++; if (b_pend[3] !== (j >= 8)) begin errs++; $display("FAIL rmid_pending edge %0d got %b exp %b", j, b_pend[3], j >= 8); end
    end
    settle();
  endtask

  task automatic test_random();
    int     npress [W];
    int     bl [W];
    logic   tgt;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < W; c++) npress[c] = 0;
      for (int ph = 0; ph < 2; ph++) begin
        tgt = (ph == 0);
        for (int c = 0; c < W; c++) bl[c] = $urandom_range(0, 3);
        for (int t = 0; t < 20; t++) begin
          for (int c = 0; c < W; c++) gpi[c] = (t < bl[c]) ? 1'($urandom % 2) : tgt;
          ack = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
          tick();
          checks++; if (a_level !== m_lvl[0]) begin errs++; $display("FAIL rnd_a_level r%0d t%0d got %b exp %b", r, t, a_level, m_lvl[0]); end
          checks++; if (b_level !== m_lvl[1]) begin errs++; $display("FAIL rnd_b_level r%0d t%0d got %b exp %b", r, t, b_level, m_lvl[1]); end
          checks++; if (b_press !== m_prs[1]) begin errs++; $display("FAIL rnd_b_press r%0d t%0d got %b exp %b", r, t, b_press, m_prs[1]); end
          checks++; if ({a_pend, b_pend} !== {m_pnd[0], m_pnd[1]}) begin errs++; $display("FAIL rnd_pending r%0d t%0d got %b exp %b", r, t, {a_pend, b_pend}, {m_pnd[0], m_pnd[1]}); end
          checks++; if ({b_ev, b_code} !== {|m_pnd[1], top_idx(m_pnd[1])}) begin errs++; $display("FAIL rnd_evt r%0d t%0d got %b/%0d exp %b/%0d", r, t, b_ev, b_code, |m_pnd[1], top_idx(m_pnd[1])); end
          for (int c = 0; c < W; c++) npress[c] += int'(b_press[c]);
        end
      end
      ack = '0;
      for (int c = 0; c < W; c++) begin
        checks++; if (npress[c] != 1) begin errs++; $display("FAIL rnd_press_count r%0d ch%0d got %0d exp 1", r, c, npress[c]); end
      end
    end
    settle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_n0();
    test_glitch();
    test_hold();
    test_evt();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
